// File: rtl/tespar_decoder.sv
// TESPAR symbol decoder: FIFO-buffered symbols expanded into signed epochs of D samples with S dips.
// First sample two cycles after the write; never stalls the encoder, drops symbols on a full FIFO.

module tespar_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    output logic                       wr_rdy,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    input  logic                       rd_rdy,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign rd_vld = (count != '0);
    assign pop    = rd_rdy & rd_vld;
    assign wr_rdy = (count != CNT_FULL) | pop;
    assign push   = wr_vld & wr_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module tespar_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int AMP        = 64,
    parameter int DIP_SHIFT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        code,
    input  logic              valid,
    output logic signed [7:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              overflow,
    output logic              illegal
);
    localparam logic [7:0] AMP_MAG = 8'(AMP);
    localparam logic [7:0] DIP_MAG = AMP_MAG - (AMP_MAG >> DIP_SHIFT);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t     state;
    logic [4:0] d_reg;
    logic [1:0] s_reg;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [4:0] j;
    logic       pol;

    logic                          legal;
    logic                          wr_rdy;
    logic                          fifo_vld;
    logic [4:0]                    hd;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          pop;

    logic [4:0] hd_off;
    logic [4:0] hd_d;
    logic [1:0] hd_s;
    logic [4:0] hd_p1;
    logic [4:0] hd_p2;

    assign legal = (code != 5'd0) && (code <= 5'd28);
    assign pop   = (state == LOAD);

    tespar_fifo #(.W(5), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .wr_vld (valid & legal),
        .wr_dat (code),
        .wr_rdy (wr_rdy),
        .rd_vld (fifo_vld),
        .rd_dat (hd),
        .rd_rdy (pop),
        .count  (fifo_count)
    );

    // Symbols 10..28 pair up: even offset gives one dip, odd offset gives two.
    assign hd_off = hd - 5'd10;
    assign hd_d   = (hd < 5'd10) ? hd : 5'd10 + (hd_off >> 1);
    assign hd_s   = (hd < 5'd10) ? 2'd0 : 2'd1 + {1'b0, hd_off[0]};
    assign hd_p1  = (hd_s == 2'd2) ? (hd_d >> 2) : (hd_d >> 1);
    assign hd_p2  = 5'(({2'b00, hd_d} * 7'd3) >> 2);

    function automatic logic [7:0] sample(input logic [4:0] idx, input logic [1:0] s,
                                          input logic [4:0] q1, input logic [4:0] q2,
                                          input logic neg);
        logic [7:0] mag;
        mag = AMP_MAG;
        if ((s != 2'd0 && idx == q1) || (s == 2'd2 && idx == q2))
            mag = DIP_MAG;
        return neg ? (~mag + 8'd1) : mag;
    endfunction

    assign busy = (fifo_count != '0) | (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            overflow <= valid & legal & ~wr_rdy;
            illegal  <= valid & ~legal;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            d_reg      <= '0;
            s_reg      <= '0;
            p1         <= '0;
            p2         <= '0;
            j          <= '0;
            pol        <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                    if (fifo_vld) state <= LOAD;
                end
                LOAD: begin
                    d_reg      <= hd_d;
                    s_reg      <= hd_s;
                    p1         <= hd_p1;
                    p2         <= hd_p2;
                    j          <= '0;
                    dout       <= sample(5'd0, hd_s, hd_p1, hd_p2, pol);
                    dout_valid <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (j == d_reg - 5'd1) begin
                        pol        <= ~pol;
                        dout       <= '0;
                        dout_valid <= 1'b0;
                        state      <= fifo_vld ? LOAD : IDLE;
                    end else begin
                        j    <= j + 5'd1;
                        dout <= sample(j + 5'd1, s_reg, p1, p2, pol);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tespar_decoder.sv
// Directed bench for tespar_decoder with a sample scoreboard fed by the stimulus.

module tb_tespar_decoder;
    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              valid = 1'b0;
    logic [4:0]        code  = 5'd0;
    logic signed [7:0] dout;
    logic              dout_valid;
    logic              busy;
    logic              overflow;
    logic              illegal;

    int checks  = 0;
    int fails   = 0;
    int ovf_cnt = 0;
    int ill_cnt = 0;
    int exp_q[$];
    bit exp_pol = 1'b0;

    always #5 clk = ~clk;

    tespar_decoder #(.FIFO_DEPTH(4), .AMP(64), .DIP_SHIFT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .code       (code),
        .valid      (valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Expected epoch for one symbol, amplitude 64 with dips of 32.
    task automatic push_epoch(input int c);
        int d, s, q1, q2, m;
        d  = (c < 10) ? c : 10 + (c - 10) / 2;
        s  = (c < 10) ? 0 : ((c - 10) % 2) + 1;
        q1 = (s == 2) ? d / 4 : d / 2;
        q2 = (3 * d) / 4;
        for (int k = 0; k < d; k++) begin
            m = 64;
            if ((s >= 1 && k == q1) || (s == 2 && k == q2)) m = 32;
            exp_q.push_back(exp_pol ? -m : m);
        end
        exp_pol = ~exp_pol;
    endtask

    // Monitor: every valid sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (overflow) ovf_cnt++;
            if (illegal)  ill_cnt++;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected sample: got %0d, expected none", int'(dout));
                end else begin
                    chk("sample", int'(dout), exp_q.pop_front());
                end
            end
        end
    end

    task automatic put(input logic [4:0] c);
        @(negedge clk);
        code  = c;
        valid = 1'b1;
    endtask

    task automatic stop();
        @(negedge clk);
        valid = 1'b0;
        code  = 5'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        exp_q.delete();
        exp_pol = 1'b0;
        chk("reset dout", int'(dout), 0);
        chk("reset dout_valid", int'(dout_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset illegal", int'(illegal), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || dout_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, " samples left"}, exp_q.size(), 0);
        chk({name, " busy after drain"}, int'(busy), 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!dout_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(dout_valid), 1);
    endtask

    initial begin
        int base;

        // single short symbol and its latency
        do_reset();
        push_epoch(3);
        put(5'd3);
        stop();
        chk("t1 dv after write", int'(dout_valid), 0);
        chk("t1 busy after write", int'(busy), 1);
        @(negedge clk);
        chk("t1 dv in load", int'(dout_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1 dv in epoch", int'(dout_valid), 1);
        end
        @(negedge clk);
        chk("t1 dv after epoch", int'(dout_valid), 0);
        chk("t1 dout after epoch", int'(dout), 0);
        chk("t1 busy after epoch", int'(busy), 0);

        // back-to-back symbols with a single gap cycle
        do_reset();
        push_epoch(3);
        push_epoch(11);
        put(5'd3);
        put(5'd11);
        stop();
        chk("t2 dv in load", int'(dout_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2 dv first epoch", int'(dout_valid), 1);
        end
        @(negedge clk);
        chk("t2 gap cycle", int'(dout_valid), 0);
        @(negedge clk);
        chk("t2 second epoch start", int'(dout_valid), 1);
        drain("t2", 100);

        // single dip, then polarity negative for the next epoch
        do_reset();
        push_epoch(12);
        put(5'd12);
        stop();
        drain("t3a", 100);
        push_epoch(1);
        put(5'd1);
        stop();
        drain("t3b", 100);

        // FIFO overflow during a long epoch
        do_reset();
        base = ovf_cnt;
        push_epoch(28);
        for (int k = 0; k < 4; k++) push_epoch(5);
        put(5'd28);
        stop();
        wait_valid("t4 epoch started", 20);
        for (int k = 0; k < 5; k++) put(5'd5);
        stop();
        drain("t4", 200);
        chk("t4 overflow pulses", ovf_cnt - base, 1);

        // illegal symbols are dropped and do not touch polarity
        do_reset();
        base = ill_cnt;
        push_epoch(2);
        push_epoch(2);
        put(5'd0);
        put(5'd2);
        chk("t5 illegal pulse for 0", int'(illegal), 1);
        put(5'd30);
        chk("t5 no pulse for 2", int'(illegal), 0);
        stop();
        chk("t5 illegal pulse for 30", int'(illegal), 1);
        put(5'd2);
        stop();
        drain("t5", 100);
        chk("t5 illegal pulses", ill_cnt - base, 2);

        // reset mid-epoch with symbols queued
        do_reset();
        push_epoch(10);
        put(5'd10);
        put(5'd4);
        put(5'd4);
        stop();
        wait_valid("t6 epoch started", 20);
        repeat (4) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_pol = 1'b0;
        chk("t6 async dout", int'(dout), 0);
        chk("t6 async dout_valid", int'(dout_valid), 0);
        chk("t6 async busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6 quiet after release", int'(busy), 0);
        push_epoch(2);
        put(5'd2);
        stop();
        drain("t6", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1);
    end
endmodule
